mcpu_program_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the MCPU core and its 256-word instruction/data RAM. It accepts a byte stream over a valid/ready handshake and packs byte pairs into 16-bit instruction words. It writes those words into consecutive RAM locations starting at address 0, verifies an XOR checksum, and holds the CPU in reset until a good image is loaded.

---
 rtl/mcpu_program_loader.sv | 135 +++++++++++++
 tb/tb_mcpu_program_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_program_loader.sv
// Purpose: boot loader; packs a byte stream into 16-bit words, writes RAM from address 0, XOR-verifies, gates MCPU reset.
// Latency: one RAM write the cycle after each low byte; done/error/cpu_reset update the cycle after the checksum byte.
// Backpressure: in_ready is low in WRITE, DONE and ERR; a byte offered then is held by the source, not consumed.
module mcpu_program_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int RAM_SIZE  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_SIZE/2-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   start,
  output logic                   mem_we,
  output logic [ADDR_SIZE-1:0]   mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_SIZE:0]     words_loaded
);

  localparam int                 BYTE_W     = WORD_SIZE / 2;
  // A count byte of zero stands for a completely filled RAM.
  localparam logic [ADDR_SIZE:0] FULL_COUNT = (ADDR_SIZE + 1)'(RAM_SIZE);

  typedef enum logic [2:0] {
    S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_SIZE-1:0] r_count;
  logic [ADDR_SIZE-1:0] r_idx;
  logic [BYTE_W-1:0]    r_hi;
  logic [BYTE_W-1:0]    r_chk;
  logic [ADDR_SIZE:0]   r_words_loaded;
  logic                 r_mem_we;
  logic [ADDR_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;

  logic                 w_xfer;
  logic [ADDR_SIZE:0]   w_target;
  logic [ADDR_SIZE:0]   w_words_inc;

  assign w_xfer       = in_valid && in_ready;
  assign w_target     = (r_count == '0) ? FULL_COUNT : {1'b0, r_count};
  assign w_words_inc  = r_words_loaded + (ADDR_SIZE + 1)'(1);

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign words_loaded = r_words_loaded;

  // State register; reset lands in COUNT so the loader is ready for a fresh image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_COUNT;
    else        r_state <= w_state_nxt;
  end

  // Next-state: byte-driven walk through count, word pairs and checksum; start only leaves DONE/ERR.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COUNT: if (w_xfer) w_state_nxt = S_HI;
      S_HI:    if (w_xfer) w_state_nxt = S_LO;
      S_LO:    if (w_xfer) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (w_words_inc == w_target) ? S_CHECK : S_HI;
      S_CHECK: if (w_xfer) w_state_nxt = (in_data == r_chk) ? S_DONE : S_ERR;
      S_DONE:  if (start) w_state_nxt = S_COUNT;
      S_ERR:   if (start) w_state_nxt = S_COUNT;
      default: w_state_nxt = S_COUNT;
    endcase
  end

  // Outputs decoded from state so reset drives them without waiting for a clock edge.
  always_comb begin
    in_ready  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (r_state)
      S_COUNT, S_HI, S_LO, S_CHECK: in_ready = 1'b1;
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word assembly, running checksum, RAM write port and progress counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count        <= '0;
      r_idx          <= '0;
      r_hi           <= '0;
      r_chk          <= '0;
      r_words_loaded <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_COUNT: if (w_xfer) begin
          r_count        <= in_data;
          r_idx          <= '0;
          r_chk          <= '0;
          r_words_loaded <= '0;
        end
        S_HI: if (w_xfer) begin
          r_hi  <= in_data;
          r_chk <= r_chk ^ in_data;
        end
        // The write is issued from a register so mem_we lands exactly in the WRITE cycle.
        S_LO: if (w_xfer) begin
          r_chk       <= r_chk ^ in_data;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_idx;
          r_mem_wdata <= {r_hi, in_data};
        end
        S_WRITE: begin
          r_idx          <= r_idx + 1'b1;
          r_words_loaded <= w_words_inc;
        end
        S_DONE, S_ERR: if (start) r_words_loaded <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_program_loader.sv
`timescale 1ns/1ps
module tb_mcpu_program_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] tb_ram[256];
  logic [15:0] exp_ram[256];

  mcpu_program_loader #(.WORD_SIZE(16), .ADDR_SIZE(8), .RAM_SIZE(256)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write is popped against the scoreboard and stored in the bench RAM.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      chk("in_ready_low_in_write", in_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.addr);
        chk("wr_data", mem_wdata, mon_e.data);
      end
      tb_ram[mem_addr] = mem_wdata;
    end
  end

  // Reference model: derive the expected writes, final count and verdict from the image bytes.
  task automatic model_image(input byte_q_t b, output int n, output bit good);
    logic [7:0] x;
    wr_t        e;
    n = (b[0] == 8'd0) ? 256 : int'(b[0]);
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      e.addr = 8'(k);
      e.data = {b[1 + 2*k], b[2 + 2*k]};
      x      = x ^ b[1 + 2*k] ^ b[2 + 2*k];
      exp_q.push_back(e);
      exp_ram[k] = e.data;
    end
    good = (b[1 + 2*n] == x);
  endtask

  task automatic check_ram(input string name);
    int bad = 0;
    for (int a = 0; a < 256; a++)
      if (tb_ram[a] !== exp_ram[a]) bad++;
    chk(name, bad, 0);
  endtask

  // Drive one complete image; called and returning at a falling edge.
  task automatic send_image(input string name, input byte_q_t b, input int max_gap, input bit with_start);
    int n;
    bit good;
    int gap;
    int stall;
    int exp_stall;
    model_image(b, n, good);
    for (int i = 0; i < b.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b[i];
      if (i == 0 && with_start) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_cpu_reset_after_start"}, cpu_reset, 1);
        chk({name, "_done_cleared"}, done, 0);
      end
      stall = 0;
      while (!in_ready && stall < 20) begin
        @(negedge clk);
        stall++;
      end
      if (stall >= 20) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: byte %0d never accepted", name, i);
      end
      // A byte following a low byte waits out the WRITE cycle unless idle time already covered it.
      exp_stall = (i >= 3 && (i % 2) == 1 && gap == 0) ? 1 : 0;
      chk({name, "_stall"}, stall, exp_stall);
      if (i == b.size() - 1) chk({name, "_done_before_chk"}, done, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({name, "_done"}, done, good);
    chk({name, "_error"}, error, !good);
    chk({name, "_cpu_reset"}, cpu_reset, !good);
    chk({name, "_words_loaded"}, words_loaded, n);
    chk({name, "_writes_pending"}, exp_q.size(), 0);
    check_ram({name, "_ram"});
  endtask

  task automatic put_byte(input logic [7:0] v);
    int w = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      checks++;
      errors++;
      $display("FAIL put_byte_timeout: byte 0x%0h never accepted", v);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_error"}, error, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_words_loaded"}, words_loaded, 0);
    chk({name, "_cpu_reset"}, cpu_reset, 1);
    chk({name, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t    img;
    logic [7:0] x;
    int         n;
    wr_t        e;
    for (int a = 0; a < 256; a++) begin
      tb_ram[a]  = 16'h0000;
      exp_ram[a] = 16'h0000;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words_loaded", words_loaded, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reference good image.
    img = '{8'h02, 8'h10, 8'h30, 8'h11, 8'h0C, 8'h3D};
    send_image("good", img, 0, 1'b0);

    // Same image with a wrong checksum, then recover with start.
    pulse_start("restart1");
    img = '{8'h02, 8'h10, 8'h30, 8'h11, 8'h0C, 8'h00};
    send_image("badchk", img, 0, 1'b0);
    pulse_start("clear_err");

    // Idle gaps on the source side.
    img = '{8'h02, 8'h10, 8'h30, 8'h11, 8'h0C, 8'h3D};
    send_image("gaps", img, 3, 1'b0);

    // Full RAM: word i = i*0x0101; the pairwise bytes cancel, so the checksum is zero.
    img = {};
    img.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < 256; i++) begin
      img.push_back(8'(i));
      img.push_back(8'(i));
      x = x ^ 8'(i) ^ 8'(i);
    end
    img.push_back(x);
    send_image("full", img, 0, 1'b1);

    // Abandon a load with an asynchronous reset between clock edges.
    pulse_start("restart2");
    e.addr = 8'h00;
    e.data = 16'h1030;
    exp_q.push_back(e);
    exp_ram[0] = 16'h1030;
    put_byte(8'h02);
    put_byte(8'h10);
    put_byte(8'h30);
    put_byte(8'h11);
    chk("mid_words_loaded", words_loaded, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_in_ready", in_ready, 1);
    chk("async_mem_we", mem_we, 0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_mem_wdata", mem_wdata, 0);
    chk("async_cpu_reset", cpu_reset, 1);
    chk("async_done", done, 0);
    chk("async_error", error, 0);
    chk("async_words_loaded", words_loaded, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    img = '{8'h02, 8'h10, 8'h30, 8'h11, 8'h0C, 8'h3D};
    send_image("after_rst", img, 0, 1'b0);

    // Reload one word from DONE; mem[1] must keep the earlier value.
    img = '{8'h01, 8'hAB, 8'hCD, 8'h66};
    send_image("reload", img, 0, 1'b1);
    chk("reload_mem1_kept", tb_ram[1], 16'h110C);

    // Random images, some with corrupted checksums.
    for (int t = 0; t < 10; t++) begin
      n   = int'($urandom_range(1, 12));
      img = {};
      img.push_back(8'(n));
      x = 8'h00;
      for (int k = 0; k < 2 * n; k++) begin
        img.push_back(8'($urandom_range(0, 255)));
        x = x ^ img[img.size() - 1];
      end
      if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
      img.push_back(x);
      send_image("rand", img, 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
